stack_ctrl: RTL and testbench
=============================

// Module: stack_ctrl
// PURPOSE
//   Call/return sequencer for the 12-bit x 8 return-address stack. Accepts call
//   (push) and return (pop) requests from ID-stage decode over a ready/req
//   handshake. Drives the stack's push/pop strobes, tracks occupancy, and
//   returns the popped target with a valid pulse. Overflow and underflow are
//   trapped here; the stack never sees an illegal push or pop.
// PARAMETERS
//   DATA_W  12  width of return address / stack entry
//   DEPTH   8   stack entries; must match attached stack
//   CNT_W   4   width of depth counter; must hold 0..DEPTH
// PORTS
//   clk         in   1       clock, all state on rising edge
//   rst         in   1       synchronous reset, active-low (rst==0 resets)
//   call_req    in   1       push request, held until accepted
//   call_addr   in   DATA_W  return address to push; sampled on acceptance
//   ret_req     in   1       pop request, held until accepted
//   req_ready   out  1       controller can accept a request this cycle
//   ret_target  out  DATA_W  popped address; valid while ret_valid==1
//   ret_valid   out  1       one-cycle pulse: return completed
//   stack_push  out  1       push strobe to stack, one cycle
//   stack_pop   out  1       pop strobe to stack, one cycle
//   stack_wdata out  DATA_W  write data to stack; valid with stack_push
//   stack_rdata in   DATA_W  top-of-stack data; valid in cycle after stack_pop
//   depth       out  CNT_W   current occupancy, 0..DEPTH
//   full        out  1       depth==DEPTH
//   empty       out  1       depth==0
//   ovf_err     out  1       sticky: call arrived while full
//   unf_err     out  1       sticky: return arrived while empty
//   err_clr     in   1       clears ovf_err/unf_err
// BEHAVIOUR
//   Reset (rst==0 at edge): state=IDLE, depth=0, ret_target=0, and all strobes,
//     ret_valid and error flags 0. This holds mid-operation too: an in-flight
//     push or pop is abandoned. The stack is reset on the same rst net.
//   All outputs are registered. The only exceptions are req_ready, full and
//     empty, which are decoded from state and depth.
//   Acceptance happens on an edge where req_ready && (call_req || ret_req).
//   FSM states: IDLE, PUSH, POP, READ. req_ready=1 only in IDLE.
//   IDLE:
//     - ret_req wins if both requests are asserted. The call is not accepted
//       and must be held by the requester.
//     - ret_req && !empty -> POP.
//     - call_req && !full -> latch call_addr into stack_wdata -> PUSH.
//     - call_req && full -> request consumed and dropped, ovf_err<=1, stay IDLE,
//       no stack_push.
//     - ret_req && empty -> request consumed, unf_err<=1, ret_target<=0,
//       ret_valid pulses next cycle, stay IDLE, no stack_pop.
//   PUSH: stack_push=1 for this cycle; depth+1 at its end; -> IDLE.
//   POP: stack_pop=1 for this cycle; depth-1 at its end; -> READ.
//   READ: ret_target<=stack_rdata at end of cycle; ret_valid=1 the following
//     cycle (back in IDLE); -> IDLE.
//   Latency from accepting edge:
//     - call: stack_push high 1 cycle later.
//     - return: stack_pop 1 cycle later, ret_valid 3 cycles later.
//   Throughput: one call per 2 cycles; one return per 3 cycles.
//   A new request may be accepted in the same IDLE cycle that ret_valid is high.
//   depth never wraps: saturates logically via the full/empty guards.
//     push/pop strobes are never issued at full/empty.
//   Error flags: err_clr clears both. If an error event and err_clr coincide,
//     set wins. Flags do not block further requests.
// TESTING
//   1. Reset: rst=0 for 2 cycles -> depth=0, empty=1, req_ready=1, all strobes
//      and flags 0.
//   2. Call 0x123 then return -> stack_push 1 cycle after accept with
//      stack_wdata=0x123, depth 0->1. Return: stack_pop, depth 1->0, ret_valid
//      with ret_target=0x123.
//   3. Push 0x001..0x008 -> full=1, depth=8. 9th call 0xABC -> no stack_push,
//      ovf_err=1, depth stays 8.
//   4. Return while empty -> no stack_pop, unf_err=1, ret_valid with
//      ret_target=0. err_clr=1 -> both flags 0. err_clr + new underflow in same
//      cycle -> unf_err=1.
//   5. call_req and ret_req together, depth=2, top 0x055 -> return serviced
//      first (ret_target=0x055). Held call accepted at next IDLE; depth ends at 2.
//   6. rst=0 in the POP cycle of a return -> no ret_valid, state IDLE, depth=0
//      next cycle.

Source files
------------

// File: rtl/stack_ctrl.sv
// Call/return sequencer for the return-address stack: handshakes ID-stage
// requests, strobes the stack, tracks occupancy and traps over/underflow.
module stack_ctrl #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              call_req,
    input  logic [DATA_W-1:0] call_addr,
    input  logic              ret_req,
    output logic              req_ready,
    output logic [DATA_W-1:0] ret_target,
    output logic              ret_valid,
    output logic              stack_push,
    output logic              stack_pop,
    output logic [DATA_W-1:0] stack_wdata,
    input  logic [DATA_W-1:0] stack_rdata,
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err,
    input  logic              err_clr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PUSH = 2'd1;
    localparam logic [1:0] POP  = 2'd2;
    localparam logic [1:0] READ = 2'd3;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [1:0] state;
    logic       ovf_evt;
    logic       unf_evt;

    assign req_ready = (state == IDLE);
    assign full      = (depth == FULL_CNT);
    assign empty     = (depth == '0);

    // ret_req has priority, so a call only counts as overflow when no return is pending
    always_comb begin
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (state == IDLE) begin
            if (ret_req) begin
                unf_evt = empty;
            end else if (call_req) begin
                ovf_evt = full;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            depth       <= '0;
            ret_target  <= '0;
            ret_valid   <= 1'b0;
            stack_push  <= 1'b0;
            stack_pop   <= 1'b0;
            stack_wdata <= '0;
            ovf_err     <= 1'b0;
            unf_err     <= 1'b0;
        end else begin
            stack_push <= 1'b0;
            stack_pop  <= 1'b0;
            ret_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (ret_req) begin
                        if (!empty) begin
                            stack_pop <= 1'b1;
                            state     <= POP;
                        end else begin
                            ret_target <= '0;
                            ret_valid  <= 1'b1;
                        end
                    end else if (call_req && !full) begin
                        stack_wdata <= call_addr;
                        stack_push  <= 1'b1;
                        state       <= PUSH;
                    end
                end
                PUSH: begin
                    depth <= depth + 1'b1;
                    state <= IDLE;
                end
                POP: begin
                    depth <= depth - 1'b1;
                    state <= READ;
                end
                READ: begin
                    ret_target <= stack_rdata;
                    ret_valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // a new error event takes precedence over a simultaneous clear
            ovf_err <= ovf_evt | (ovf_err & ~err_clr);
            unf_err <= unf_evt | (unf_err & ~err_clr);
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: vector table plus hand-written corner
// sequences, with a behavioural stack attached and a push/return scoreboard.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        call_req = 1'b0;
    logic [11:0] call_addr = '0;
    logic        ret_req = 1'b0;
    logic        req_ready;
    logic [11:0] ret_target;
    logic        ret_valid;
    logic        stack_push;
    logic        stack_pop;
    logic [11:0] stack_wdata;
    logic [11:0] stack_rdata;
    logic [3:0]  depth;
    logic        full;
    logic        empty;
    logic        ovf_err;
    logic        unf_err;
    logic        err_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [11:0] push_q[$];
    logic [11:0] ret_q[$];
    logic [11:0] ref_stk[$];

    always #5 clk = ~clk;

    stack_ctrl #(.DATA_W(12), .DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .call_req(call_req), .call_addr(call_addr),
        .ret_req(ret_req), .req_ready(req_ready), .ret_target(ret_target),
        .ret_valid(ret_valid), .stack_push(stack_push), .stack_pop(stack_pop),
        .stack_wdata(stack_wdata), .stack_rdata(stack_rdata), .depth(depth),
        .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err),
        .err_clr(err_clr)
    );

    // Behavioural 8-entry stack: read data appears in the cycle after the pop strobe
    logic [11:0] mem [8];
    logic [3:0]  sp;
    always @(posedge clk) begin
        if (!rst) begin
            sp          <= '0;
            stack_rdata <= '0;
        end else if (stack_push) begin
            mem[sp[2:0]] <= stack_wdata;
            sp           <= sp + 4'd1;
        end else if (stack_pop) begin
            stack_rdata <= mem[3'(sp - 4'd1)];
            sp          <= sp - 4'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every push strobe and every ret_valid must match a queued expectation
    always @(negedge clk) begin
        if (rst) begin
            if (stack_push) begin
                if (push_q.size() == 0) chk("unexpected_push", 32'(stack_push), 32'd0);
                else chk("push_wdata", 32'(stack_wdata), 32'(push_q.pop_front()));
            end
            if (ret_valid) begin
                if (ret_q.size() == 0) chk("unexpected_ret_valid", 32'(ret_valid), 32'd0);
                else chk("ret_target", 32'(ret_target), 32'(ret_q.pop_front()));
            end
        end
    end

    // Reference model: record what the DUT must produce for an accepted request
    task automatic model(input logic c, input logic r, input logic [11:0] a);
        if (r) begin
            if (ref_stk.size() > 0) ret_q.push_back(ref_stk.pop_back());
            else ret_q.push_back(12'h000);
        end else if (c && ref_stk.size() < 8) begin
            ref_stk.push_back(a);
            push_q.push_back(a);
        end
    endtask

    // Drive a request for exactly one accepting edge; returns at accept edge + #1
    task automatic issue(input logic c, input logic r, input logic [11:0] a, input logic clr);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        model(c, r, a);
        call_req  = c;
        ret_req   = r;
        call_addr = a;
        err_clr   = clr;
        @(posedge clk);
        #1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        err_clr  = 1'b0;
    endtask

    typedef struct {
        logic        c;
        logic        r;
        logic [11:0] addr;
        logic        e_push;
        logic        e_pop;
        logic        e_rv1;
        logic        e_rv3;
        logic [3:0]  e_depth;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;

        // call 0x123 then return it
        vecs.push_back('{1,0,12'h123, 1,0,0,0, 4'd1,0,0,0,0});
        vecs.push_back('{0,1,12'h000, 0,1,0,1, 4'd0,0,1,0,0});
        // fill to full with 0x001..0x008
        for (int i = 1; i <= 8; i++) begin
            v = '{1,0,12'(i), 1,0,0,0, 4'(i),(i == 8),0,0,0};
            vecs.push_back(v);
        end
        // call while full is dropped
        vecs.push_back('{1,0,12'hABC, 0,0,0,0, 4'd8,1,0,1,0});
        // drain; ovf_err stays sticky
        for (int i = 7; i >= 0; i--) begin
            v = '{0,1,12'h000, 0,1,0,1, 4'(i),0,(i == 0),1,0};
            vecs.push_back(v);
        end
        // return while empty
        vecs.push_back('{0,1,12'h000, 0,0,1,0, 4'd0,0,1,1,1});

        // reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_strobes", {29'd0, stack_push, stack_pop, ret_valid}, 32'd0);
        chk("rst_flags", {30'd0, ovf_err, unf_err}, 32'd0);
        chk("rst_target", 32'(ret_target), 32'd0);
        rst = 1'b1;

        foreach (vecs[k]) begin
            v = vecs[k];
            issue(v.c, v.r, v.addr, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_push", k), 32'(stack_push), 32'(v.e_push));
            chk($sformatf("v%0d_pop", k), 32'(stack_pop), 32'(v.e_pop));
            chk($sformatf("v%0d_rv1", k), 32'(ret_valid), 32'(v.e_rv1));
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_rv3", k), 32'(ret_valid), 32'(v.e_rv3));
            chk($sformatf("v%0d_depth", k), 32'(depth), 32'(v.e_depth));
            chk($sformatf("v%0d_full", k), 32'(full), 32'(v.e_full));
            chk($sformatf("v%0d_empty", k), 32'(empty), 32'(v.e_empty));
            chk($sformatf("v%0d_ovf", k), 32'(ovf_err), 32'(v.e_ovf));
            chk($sformatf("v%0d_unf", k), 32'(unf_err), 32'(v.e_unf));
        end

        // err_clr alone clears both flags
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("clr_flags", {30'd0, ovf_err, unf_err}, 32'd0);

        // err_clr coinciding with a new underflow: set wins
        issue(1'b0, 1'b1, 12'h000, 1'b1);
        @(negedge clk);
        chk("clr_vs_unf", 32'(unf_err), 32'd1);
        chk("clr_vs_unf_ovf", 32'(ovf_err), 32'd0);
        repeat (2) @(negedge clk);

        // simultaneous call and return at depth 2, top 0x055: return first, call held
        issue(1'b1, 1'b0, 12'h044, 1'b0);
        repeat (2) @(negedge clk);
        issue(1'b1, 1'b0, 12'h055, 1'b0);
        repeat (2) @(negedge clk);
        begin
            int n = 0;
            @(negedge clk);
            model(1'b0, 1'b1, 12'h000);
            model(1'b1, 1'b0, 12'h0AA);
            call_req  = 1'b1;
            ret_req   = 1'b1;
            call_addr = 12'h0AA;
            @(posedge clk);
            #1 ret_req = 1'b0;
            @(negedge clk);
            chk("both_pop_first", {30'd0, stack_pop, stack_push}, 32'd2);
            while (!req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("both_ready_wait", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1 call_req = 1'b0;
            repeat (3) @(negedge clk);
            chk("both_depth", 32'(depth), 32'd2);
        end

        // reset during the POP cycle of a return abandons it
        issue(1'b0, 1'b0, 12'h000, 1'b0);
        begin
            int n = 0;
            @(negedge clk);
            while (!req_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            ret_req = 1'b1;
            @(posedge clk);
            #1 ret_req = 1'b0;
            chk("rstpop_pop", 32'(stack_pop), 32'd1);
            rst = 1'b0;
            @(posedge clk);
            #1 rst = 1'b1;
            ref_stk.delete();
            @(negedge clk);
            chk("rstpop_depth", 32'(depth), 32'd0);
            chk("rstpop_ready", 32'(req_ready), 32'd1);
            for (int i = 0; i < 4; i++) begin
                chk("rstpop_no_rv", 32'(ret_valid), 32'd0);
                @(negedge clk);
            end
        end

        chk("push_q_drained", 32'(push_q.size()), 32'd0);
        chk("ret_q_drained", 32'(ret_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
